// File: rtl/s_mem_arb_pkg.sv
// Shared constants and types for the S-box RAM arbiter.
// Optional build macro: S_ARB_ROUND_ROBIN_EN (round-robin winner selection).
package s_mem_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;

    localparam int REQ_INIT    = 0;
    localparam int REQ_SHUFFLE = 1;
    localparam int REQ_COMPUTE = 2;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] owner_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/s_mem_arb_pick.sv
// Combinational winner select: first asserted request scanning upward from start_i,
// wrapping around. A start of zero gives plain lowest-index-first priority.
module s_mem_arb_pick
    import s_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_o && req_i[j] && (((int'(start_i) + k) % NUM_REQ) == j)) begin
                    any_o       = 1'b1;
                    gnt_oh_o[j] = 1'b1;
                    gnt_idx_o   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// Request/grant/lock arbiter for the single-port S-box RAM shared by the RC4 engines.
// Optional build macro: S_ARB_ROUND_ROBIN_EN (rotate priority after each grant).
module s_mem_arbiter
    import s_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    input  logic [NUM_REQ-1:0]        wren,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]   rd_id_q, rd_id_d;

    logic               own_req, own_lock, own_wren;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_wdata;
    logic               release_c, arbitrate_c;
    logic [IDX_W-1:0]   start_c;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

`ifdef S_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    assign start_c = ptr_q;
`else
    assign start_c = '0;
`endif

    // Only the owner's slice ever reaches the RAM; everything is zero with no owner.
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_wren  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == ST_OWNED && int'(owner_q) == i) begin
                own_req   = req[i];
                own_lock  = lock[i];
                own_wren  = wren[i];
                own_addr  = addr[i*ADDR_W +: ADDR_W];
                own_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign mem_addr  = own_addr;
    assign mem_wdata = own_wdata;
    assign mem_wren  = own_req & own_wren;

    assign release_c   = (state_q == ST_OWNED) & ~own_req & ~own_lock;
    assign arbitrate_c = (state_q == ST_IDLE) | release_c;

    s_mem_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i     (req),
        .start_i   (start_c),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        rd_vld_d = own_req & ~own_wren;
        rd_id_d  = owner_q;
`ifdef S_ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        if (arbitrate_c) begin
            if (pick_any) begin
                state_d = ST_OWNED;
                owner_d = pick_idx;
                gnt_d   = pick_oh;
`ifdef S_ARB_ROUND_ROBIN_EN
                ptr_d   = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
`endif
            end else begin
                state_d = ST_IDLE;
                owner_d = '0;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            gnt_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= '0;
`ifdef S_ARB_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
`ifdef S_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // The read id is captured with the access, so routing survives a grant change.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid[i] = rd_vld_q && (int'(rd_id_q) == i);
        end
    end

    assign gnt   = gnt_q;
    assign busy  = (state_q == ST_OWNED);
    assign rdata = mem_q;

endmodule
